// File: rtl/banzai_pkg.sv
// Shared types and constants for the banzAI AXI-Lite register front-end.
package banzai_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'd0,
    EXOKAY = 2'd1,
    SLVERR = 2'd2,
    DECERR = 2'd3
  } axil_resp_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WCOLLECT,
    ST_ISSUE,
    ST_WAIT,
    ST_BRESP,
    ST_RRESP
  } regif_state_e;

  localparam logic [31:0] ERR_RDATA = 32'hDEADBEEF;

endpackage

// File: rtl/banzai_axil_decode.sv
// Window and alignment check for one AXI byte address; yields the word offset
// of the address relative to the start of the register window.
module banzai_axil_decode
  import banzai_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int                    SPAN_BYTES = 4096
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic                  hit,
  output logic                  aligned,
  output logic [ADDR_WIDTH-3:0] word_offset
);

  logic [ADDR_WIDTH-1:0] offset;
  logic [ADDR_WIDTH:0]   span;

  // The extra span bit keeps a window reaching the top of the address space representable.
  always_comb begin
    offset      = addr - BASE_ADDR;
    span        = (ADDR_WIDTH + 1)'(SPAN_BYTES);
    hit         = (addr >= BASE_ADDR) && ({1'b0, offset} < span);
    aligned     = (addr[1:0] == 2'b00);
    word_offset = offset[ADDR_WIDTH-1:2];
  end

endmodule

// File: rtl/banzai_axil_regif.sv
// AXI-Lite slave that turns each read or write into a single request on the
// core register port, one transaction in flight, with decode and timeout.
module banzai_axil_regif
  import banzai_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int                    SPAN_BYTES = 4096,
  parameter int                    TIMEOUT    = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    aw_valid,
  output logic                    aw_ready,
  input  logic [ADDR_WIDTH-1:0]   aw_addr,
  input  logic                    w_valid,
  output logic                    w_ready,
  input  logic [DATA_WIDTH-1:0]   w_data,
  input  logic [DATA_WIDTH/8-1:0] w_strb,
  output logic                    b_valid,
  input  logic                    b_ready,
  output logic [1:0]              b_resp,
  input  logic                    ar_valid,
  output logic                    ar_ready,
  input  logic [ADDR_WIDTH-1:0]   ar_addr,
  output logic                    r_valid,
  input  logic                    r_ready,
  output logic [DATA_WIDTH-1:0]   r_data,
  output logic [1:0]              r_resp,
  output logic                    req_valid,
  input  logic                    req_ready,
  output logic                    req_we,
  output logic [ADDR_WIDTH-3:0]   req_addr,
  output logic [DATA_WIDTH-1:0]   req_wdata,
  output logic [DATA_WIDTH/8-1:0] req_wstrb,
  input  logic                    rsp_valid,
  input  logic [DATA_WIDTH-1:0]   rsp_rdata,
  input  logic                    rsp_err
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  regif_state_e            state_q, state_d;
  logic                    rr_q, rr_d;
  logic                    have_aw_q, have_aw_d;
  logic                    have_w_q, have_w_d;
  logic [ADDR_WIDTH-1:0]   aw_addr_q, aw_addr_d;
  logic [DATA_WIDTH-1:0]   w_data_q, w_data_d;
  logic [DATA_WIDTH/8-1:0] w_strb_q, w_strb_d;
  logic                    req_valid_q, req_valid_d;
  logic                    req_we_q, req_we_d;
  logic [ADDR_WIDTH-3:0]   req_addr_q, req_addr_d;
  logic [DATA_WIDTH-1:0]   req_wdata_q, req_wdata_d;
  logic [DATA_WIDTH/8-1:0] req_wstrb_q, req_wstrb_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    late_q, late_d;
  logic                    b_valid_q, b_valid_d;
  axil_resp_e              b_resp_q, b_resp_d;
  logic                    r_valid_q, r_valid_d;
  axil_resp_e              r_resp_q, r_resp_d;
  logic [DATA_WIDTH-1:0]   r_data_q, r_data_d;

  logic                    conflict;
  logic                    aw_hs, w_hs, ar_hs;
  logic                    start_wr, start_rd;
  logic [ADDR_WIDTH-1:0]   start_addr;
  logic [DATA_WIDTH-1:0]   start_wdata;
  logic [DATA_WIDTH/8-1:0] start_wstrb;
  logic                    dec_hit, dec_aligned;
  logic [ADDR_WIDTH-3:0]   dec_offset;
  logic                    fin, fin_we;
  axil_resp_e              fin_resp;
  logic [DATA_WIDTH-1:0]   fin_rdata;

  // Readies are held low throughout reset; when AR and AW/W contend, the round-robin bit picks the winner.
  always_comb begin
    conflict = ar_valid && (aw_valid || w_valid);
    aw_ready = 1'b0;
    w_ready  = 1'b0;
    ar_ready = 1'b0;
    if (!rst) begin
      if (state_q == ST_IDLE) begin
        aw_ready = !(conflict && rr_q);
        w_ready  = !(conflict && rr_q);
        ar_ready = !(conflict && !rr_q);
      end else if (state_q == ST_WCOLLECT) begin
        aw_ready = !have_aw_q;
        w_ready  = !have_w_q;
      end
    end
  end

  assign aw_hs = aw_valid && aw_ready;
  assign w_hs  = w_valid && w_ready;
  assign ar_hs = ar_valid && ar_ready;

  always_comb begin
    start_rd    = (state_q == ST_IDLE) && ar_hs;
    start_wr    = ((state_q == ST_IDLE) && aw_hs && w_hs) ||
                  ((state_q == ST_WCOLLECT) && (have_aw_q || aw_hs) && (have_w_q || w_hs));
    start_addr  = aw_addr;
    start_wdata = w_data;
    start_wstrb = w_strb;
    if (start_rd) begin
      start_addr = ar_addr;
    end else if (state_q == ST_WCOLLECT) begin
      if (have_aw_q) start_addr = aw_addr_q;
      if (have_w_q) begin
        start_wdata = w_data_q;
        start_wstrb = w_strb_q;
      end
    end
  end

  banzai_axil_decode #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .BASE_ADDR  (BASE_ADDR),
    .SPAN_BYTES (SPAN_BYTES)
  ) u_decode (
    .addr        (start_addr),
    .hit         (dec_hit),
    .aligned     (dec_aligned),
    .word_offset (dec_offset)
  );

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    have_aw_d   = have_aw_q;
    have_w_d    = have_w_q;
    aw_addr_d   = aw_hs ? aw_addr : aw_addr_q;
    w_data_d    = w_hs ? w_data : w_data_q;
    w_strb_d    = w_hs ? w_strb : w_strb_q;
    req_valid_d = req_valid_q;
    req_we_d    = req_we_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    req_wstrb_d = req_wstrb_q;
    cnt_d       = cnt_q;
    late_d      = late_q;
    b_valid_d   = b_valid_q;
    b_resp_d    = b_resp_q;
    r_valid_d   = r_valid_q;
    r_resp_d    = r_resp_q;
    r_data_d    = r_data_q;
    fin         = 1'b0;
    fin_resp    = OKAY;
    fin_rdata   = '0;

    // The first response after a timeout belongs to the abandoned request and is swallowed here.
    if (rsp_valid && late_q) late_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (ar_hs || aw_hs || w_hs) rr_d = ~rr_q;
        if (!start_rd && !start_wr && (aw_hs || w_hs)) begin
          state_d   = ST_WCOLLECT;
          have_aw_d = aw_hs;
          have_w_d  = w_hs;
        end
      end
      ST_WCOLLECT: begin
        if (aw_hs) have_aw_d = 1'b1;
        if (w_hs) have_w_d = 1'b1;
        if (start_wr) begin
          have_aw_d = 1'b0;
          have_w_d  = 1'b0;
        end
      end
      ST_ISSUE: begin
        if (req_ready) begin
          req_valid_d = 1'b0;
          cnt_d       = '0;
          state_d     = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (rsp_valid && !late_q) begin
          fin       = 1'b1;
          fin_resp  = rsp_err ? SLVERR : OKAY;
          fin_rdata = rsp_rdata;
        end else if (TIMEOUT != 0 && cnt_q == TMO_LAST) begin
          fin       = 1'b1;
          fin_resp  = SLVERR;
          fin_rdata = DATA_WIDTH'(ERR_RDATA);
          late_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_BRESP: begin
        if (b_ready) begin
          b_valid_d = 1'b0;
          state_d   = ST_IDLE;
        end
      end
      ST_RRESP: begin
        if (r_ready) begin
          r_valid_d = 1'b0;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (start_wr || start_rd) begin
      req_we_d = start_wr;
      if (!dec_hit) begin
        fin       = 1'b1;
        fin_resp  = DECERR;
        fin_rdata = DATA_WIDTH'(ERR_RDATA);
      end else if (!dec_aligned) begin
        fin       = 1'b1;
        fin_resp  = SLVERR;
        fin_rdata = DATA_WIDTH'(ERR_RDATA);
      end else begin
        state_d     = ST_ISSUE;
        req_valid_d = 1'b1;
        req_addr_d  = dec_offset;
        req_wdata_d = start_wr ? start_wdata : '0;
        req_wstrb_d = start_wr ? start_wstrb : '0;
      end
    end

    fin_we = (start_wr || start_rd) ? start_wr : req_we_q;
    if (fin) begin
      if (fin_we) begin
        state_d   = ST_BRESP;
        b_valid_d = 1'b1;
        b_resp_d  = fin_resp;
      end else begin
        state_d   = ST_RRESP;
        r_valid_d = 1'b1;
        r_resp_d  = fin_resp;
        r_data_d  = fin_rdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rr_q        <= 1'b0;
      have_aw_q   <= 1'b0;
      have_w_q    <= 1'b0;
      aw_addr_q   <= '0;
      w_data_q    <= '0;
      w_strb_q    <= '0;
      req_valid_q <= 1'b0;
      req_we_q    <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      req_wstrb_q <= '0;
      cnt_q       <= '0;
      late_q      <= 1'b0;
      b_valid_q   <= 1'b0;
      b_resp_q    <= OKAY;
      r_valid_q   <= 1'b0;
      r_resp_q    <= OKAY;
      r_data_q    <= '0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      have_aw_q   <= have_aw_d;
      have_w_q    <= have_w_d;
      aw_addr_q   <= aw_addr_d;
      w_data_q    <= w_data_d;
      w_strb_q    <= w_strb_d;
      req_valid_q <= req_valid_d;
      req_we_q    <= req_we_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
      req_wstrb_q <= req_wstrb_d;
      cnt_q       <= cnt_d;
      late_q      <= late_d;
      b_valid_q   <= b_valid_d;
      b_resp_q    <= b_resp_d;
      r_valid_q   <= r_valid_d;
      r_resp_q    <= r_resp_d;
      r_data_q    <= r_data_d;
    end
  end

  assign req_valid = req_valid_q;
  assign req_we    = req_we_q;
  assign req_addr  = req_addr_q;
  assign req_wdata = req_wdata_q;
  assign req_wstrb = req_wstrb_q;
  assign b_valid   = b_valid_q;
  assign b_resp    = b_resp_q;
  assign r_valid   = r_valid_q;
  assign r_resp    = r_resp_q;
  assign r_data    = r_data_q;

  // A core response may never land in the same cycle its request is accepted.
  rsp_not_in_accept_cycle: assert property (@(posedge clk) disable iff (rst)
    !(req_valid && req_ready && rsp_valid));

endmodule

// File: tb/tb_banzai_axil_regif.sv
// Directed bench for banzai_axil_regif: drives AXI-Lite transactions, models a
// simple core responder and checks responses against hand-computed values.
module tb_banzai_axil_regif;

  logic        clk = 1'b0;
  logic        rst;
  logic        aw_valid, aw_ready;
  logic [31:0] aw_addr;
  logic        w_valid, w_ready;
  logic [31:0] w_data;
  logic [3:0]  w_strb;
  logic        b_valid, b_ready;
  logic [1:0]  b_resp;
  logic        ar_valid, ar_ready;
  logic [31:0] ar_addr;
  logic        r_valid, r_ready;
  logic [31:0] r_data;
  logic [1:0]  r_resp;
  logic        req_valid, req_ready, req_we;
  logic [29:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;

  int n_checks = 0;
  int n_pass   = 0;

  bit          core_auto, core_err;
  logic [31:0] core_rdata;

  bit          aw_hs_s, w_hs_s, ar_hs_s, b_hs_s, r_hs_s;
  logic [1:0]  b_resp_s, r_resp_s;
  logic [31:0] r_data_s;

  logic        log_we[$];
  logic [29:0] log_addr[$];
  logic [31:0] log_wdata[$];
  logic [3:0]  log_wstrb[$];

  always #5 clk = ~clk;

  banzai_axil_regif dut (
    .clk       (clk),
    .rst       (rst),
    .aw_valid  (aw_valid),
    .aw_ready  (aw_ready),
    .aw_addr   (aw_addr),
    .w_valid   (w_valid),
    .w_ready   (w_ready),
    .w_data    (w_data),
    .w_strb    (w_strb),
    .b_valid   (b_valid),
    .b_ready   (b_ready),
    .b_resp    (b_resp),
    .ar_valid  (ar_valid),
    .ar_ready  (ar_ready),
    .ar_addr   (ar_addr),
    .r_valid   (r_valid),
    .r_ready   (r_ready),
    .r_data    (r_data),
    .r_resp    (r_resp),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_wstrb (req_wstrb),
    .rsp_valid (rsp_valid),
    .rsp_err   (rsp_err),
    .rsp_rdata (rsp_rdata)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
  endtask

  // Runs one clock from a negedge: samples handshakes mid-cycle, then answers an accepted request one cycle later.
  task automatic stepCycle;
    logic fire;
    #2;
    fire    = req_valid && req_ready;
    aw_hs_s = aw_valid && aw_ready;
    w_hs_s  = w_valid && w_ready;
    ar_hs_s = ar_valid && ar_ready;
    b_hs_s  = b_valid && b_ready;
    r_hs_s  = r_valid && r_ready;
    if (b_hs_s) b_resp_s = b_resp;
    if (r_hs_s) begin
      r_resp_s = r_resp;
      r_data_s = r_data;
    end
    if (fire) begin
      log_we.push_back(req_we);
      log_addr.push_back(req_addr);
      log_wdata.push_back(req_wdata);
      log_wstrb.push_back(req_wstrb);
    end
    @(negedge clk);
    rsp_valid = 1'b0;
    rsp_err   = 1'b0;
    if (fire && core_auto) begin
      rsp_valid = 1'b1;
      rsp_err   = core_err;
      rsp_rdata = core_rdata;
    end
  endtask

  // One full AXI-Lite transaction; cycles counts clock edges from the first address/data cycle to the response handshake.
  task automatic applyStimulus(input bit is_wr, input logic [31:0] addr, input logic [31:0] data,
                               input logic [3:0] strb, input bit w_first,
                               output logic [1:0] resp, output logic [31:0] rdata, output int cycles);
    bit done = 1'b0;
    bit aw_done = 1'b0;
    cycles = 0;
    resp   = 2'bxx;
    rdata  = 'x;
    if (is_wr) begin
      w_valid = 1'b1;
      w_data  = data;
      w_strb  = strb;
      if (!w_first) begin
        aw_valid = 1'b1;
        aw_addr  = addr;
      end
      while (!done && cycles < 400) begin
        stepCycle;
        cycles++;
        if (w_hs_s) w_valid = 1'b0;
        if (aw_hs_s) begin
          aw_valid = 1'b0;
          aw_done  = 1'b1;
        end else if (!aw_done && !aw_valid) begin
          aw_valid = 1'b1;
          aw_addr  = addr;
        end
        if (b_hs_s) begin
          resp = b_resp_s;
          done = 1'b1;
        end
      end
    end else begin
      ar_valid = 1'b1;
      ar_addr  = addr;
      while (!done && cycles < 400) begin
        stepCycle;
        cycles++;
        if (ar_hs_s) ar_valid = 1'b0;
        if (r_hs_s) begin
          resp  = r_resp_s;
          rdata = r_data_s;
          done  = 1'b1;
        end
      end
    end
    aw_valid = 1'b0;
    w_valid  = 1'b0;
    ar_valid = 1'b0;
    checkOutput("txn_completed", done, 1);
  endtask

  initial begin
    logic [1:0]  resp;
    logic [31:0] rdata;
    int          cyc;
    int          base;
    int          b_at, r_at;
    logic [1:0]  arb_bresp, arb_rresp;
    logic [31:0] arb_rdata;

    rst = 1'b1;
    aw_valid = 1'b0; aw_addr = '0;
    w_valid = 1'b0; w_data = '0; w_strb = '0;
    ar_valid = 1'b0; ar_addr = '0;
    b_ready = 1'b1; r_ready = 1'b1;
    req_ready = 1'b1;
    rsp_valid = 1'b0; rsp_err = 1'b0; rsp_rdata = '0;
    core_auto = 1'b1; core_err = 1'b0; core_rdata = '0;

    @(negedge clk);
    stepCycle;
    stepCycle;
    #1;
    checkOutput("rst_aw_ready", aw_ready, 0);
    checkOutput("rst_w_ready", w_ready, 0);
    checkOutput("rst_ar_ready", ar_ready, 0);
    checkOutput("rst_req_valid", req_valid, 0);
    checkOutput("rst_b_valid", b_valid, 0);
    checkOutput("rst_r_valid", r_valid, 0);
    checkOutput("rst_r_data", r_data, 0);
    checkOutput("rst_resps", {b_resp, r_resp}, 0);
    rst = 1'b0;
    #1;
    checkOutput("idle_aw_ready", aw_ready, 1);
    checkOutput("idle_ar_ready", ar_ready, 1);

    // Aligned write, AW and W together, zero-wait core.
    base = log_addr.size();
    applyStimulus(1'b1, 32'h0000_0010, 32'hCAFE_0001, 4'hF, 1'b0, resp, rdata, cyc);
    checkOutput("wr1_req_count", log_addr.size() - base, 1);
    checkOutput("wr1_req_we", log_we[base], 1);
    checkOutput("wr1_req_addr", log_addr[base], 4);
    checkOutput("wr1_req_wdata", log_wdata[base], 32'hCAFE_0001);
    checkOutput("wr1_req_wstrb", log_wstrb[base], 4'hF);
    checkOutput("wr1_bresp", resp, 2'b00);
    checkOutput("wr1_round_trip", cyc, 4);

    // W arrives one cycle ahead of AW.
    base = log_addr.size();
    applyStimulus(1'b1, 32'h0000_0008, 32'h0000_0055, 4'h3, 1'b1, resp, rdata, cyc);
    checkOutput("wfirst_req_count", log_addr.size() - base, 1);
    checkOutput("wfirst_req_addr", log_addr[base], 2);
    checkOutput("wfirst_req_wdata", log_wdata[base], 32'h55);
    checkOutput("wfirst_req_wstrb", log_wstrb[base], 4'h3);
    checkOutput("wfirst_bresp", resp, 2'b00);

    // AR and AW/W contend right after reset: the write wins first.
    rst = 1'b1;
    stepCycle;
    rst = 1'b0;
    base = log_addr.size();
    core_rdata = 32'h1234_5678;
    aw_valid = 1'b1; aw_addr = 32'h0000_000C;
    w_valid = 1'b1; w_data = 32'hA5A5_0003; w_strb = 4'hF;
    ar_valid = 1'b1; ar_addr = 32'h0000_0004;
    #1;
    checkOutput("arb_ar_ready_low", ar_ready, 0);
    checkOutput("arb_aw_ready_high", aw_ready, 1);
    b_at = 0; r_at = 0;
    arb_bresp = 2'bxx; arb_rresp = 2'bxx; arb_rdata = 'x;
    for (int i = 1; i <= 60 && (b_at == 0 || r_at == 0); i++) begin
      stepCycle;
      if (aw_hs_s) aw_valid = 1'b0;
      if (w_hs_s) w_valid = 1'b0;
      if (ar_hs_s) ar_valid = 1'b0;
      if (b_hs_s) begin b_at = i; arb_bresp = b_resp_s; end
      if (r_hs_s) begin r_at = i; arb_rresp = r_resp_s; arb_rdata = r_data_s; end
    end
    aw_valid = 1'b0; w_valid = 1'b0; ar_valid = 1'b0;
    checkOutput("arb_both_done", (b_at != 0) && (r_at != 0), 1);
    checkOutput("arb_write_first", b_at < r_at, 1);
    checkOutput("arb_req_count", log_addr.size() - base, 2);
    checkOutput("arb_req0", {log_we[base], log_addr[base]}, {1'b1, 30'd3});
    checkOutput("arb_req1", {log_we[base+1], log_addr[base+1]}, {1'b0, 30'd1});
    checkOutput("arb_bresp", arb_bresp, 2'b00);
    checkOutput("arb_rresp", arb_rresp, 2'b00);
    checkOutput("arb_rdata", arb_rdata, 32'h1234_5678);

    // Decode errors never reach the core.
    base = log_addr.size();
    applyStimulus(1'b0, 32'h0000_2000, 32'h0, 4'h0, 1'b0, resp, rdata, cyc);
    checkOutput("decerr_no_req", log_addr.size() - base, 0);
    checkOutput("decerr_rresp", resp, 2'b11);
    checkOutput("decerr_rdata", rdata, 32'hDEAD_BEEF);
    applyStimulus(1'b0, 32'h0000_0006, 32'h0, 4'h0, 1'b0, resp, rdata, cyc);
    checkOutput("misalign_no_req", log_addr.size() - base, 0);
    checkOutput("misalign_rresp", resp, 2'b10);
    checkOutput("misalign_rdata", rdata, 32'hDEAD_BEEF);

    // Core flags an error on a write.
    core_err = 1'b1;
    base = log_addr.size();
    applyStimulus(1'b1, 32'h0000_0000, 32'h0000_0077, 4'hF, 1'b0, resp, rdata, cyc);
    core_err = 1'b0;
    checkOutput("coreerr_req_count", log_addr.size() - base, 1);
    checkOutput("coreerr_bresp", resp, 2'b10);

    // Core never answers: 255 WAIT cycles then SLVERR; a late response is dropped.
    core_auto = 1'b0;
    base = log_addr.size();
    applyStimulus(1'b0, 32'h0000_0000, 32'h0, 4'h0, 1'b0, resp, rdata, cyc);
    checkOutput("tmo_req_count", log_addr.size() - base, 1);
    checkOutput("tmo_rresp", resp, 2'b10);
    checkOutput("tmo_latency", cyc, 258);
    rsp_valid = 1'b1;
    rsp_rdata = 32'hBAD0_BAD0;
    stepCycle;
    checkOutput("late_rsp_no_rvalid", r_valid, 0);
    checkOutput("late_rsp_no_bvalid", b_valid, 0);
    core_auto  = 1'b1;
    core_rdata = 32'h1111_2222;
    applyStimulus(1'b0, 32'h0000_0004, 32'h0, 4'h0, 1'b0, resp, rdata, cyc);
    checkOutput("after_late_rresp", resp, 2'b00);
    checkOutput("after_late_rdata", rdata, 32'h1111_2222);

    // Reset while the core owes a response.
    core_auto = 1'b0;
    ar_valid = 1'b1; ar_addr = 32'h0000_0000;
    stepCycle;
    ar_valid = 1'b0;
    stepCycle;
    stepCycle;
    rst = 1'b1;
    stepCycle;
    #1;
    checkOutput("rst_wait_r_data", r_data, 0);
    checkOutput("rst_wait_b_resp", b_resp, 0);
    checkOutput("rst_wait_readies", {aw_ready, w_ready, ar_ready}, 0);
    checkOutput("rst_wait_valids", {req_valid, b_valid, r_valid}, 0);
    rst = 1'b0;

    // Reset while a request is still being offered to a stalled core.
    req_ready = 1'b0;
    ar_valid = 1'b1; ar_addr = 32'h0000_0000;
    stepCycle;
    ar_valid = 1'b0;
    stepCycle;
    checkOutput("issue_req_valid_held", req_valid, 1);
    checkOutput("issue_req_we", req_we, 0);
    rst = 1'b1;
    stepCycle;
    checkOutput("rst_issue_req_valid", req_valid, 0);
    rst = 1'b0;
    req_ready = 1'b1;
    core_auto = 1'b1;

    // The interface recovers cleanly after reset.
    base = log_addr.size();
    applyStimulus(1'b1, 32'h0000_0020, 32'h0000_0020, 4'hF, 1'b0, resp, rdata, cyc);
    checkOutput("recover_req_count", log_addr.size() - base, 1);
    checkOutput("recover_req_addr", log_addr[base], 8);
    checkOutput("recover_bresp", resp, 2'b00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
